// File: rtl/updown_pkg.sv
// Shared definitions for the up/down direction controller: state encoding,
// counter width and default turnaround limits.
package updown_pkg;

  localparam int CNT_W = 4;

  localparam logic [CNT_W-1:0] LOW_LIMIT_DEF  = 4'd0;
  localparam logic [CNT_W-1:0] HIGH_LIMIT_DEF = 4'd15;

  typedef enum logic {
    S_DOWN = 1'b0,
    S_UP   = 1'b1
  } dir_state_e;

  function automatic dir_state_e dir_flip(input dir_state_e s);
    return (s == S_UP) ? S_DOWN : S_UP;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// 2-flop synchroniser plus level debouncer; emits a registered one-cycle pulse per
// accepted rising level, 2+DEBOUNCE_CYCLES edges after a clean press. No backpressure.
module btn_debounce
  import updown_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          pulse_q, pulse_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The level is accepted on the edge at which the mismatch run would reach
  // DEBOUNCE_CYCLES, so the counter never actually holds that value.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    pulse_d  = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        pulse_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      pulse_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      pulse_q  <= pulse_d;
      cnt_q    <= cnt_d;
    end
  end

  assign btn_pulse = pulse_q;

endmodule

// File: rtl/updown_dir_ctrl.sv
// Direction controller for a 4-bit up/down counter: button toggle plus auto ping-pong.
// Direction changes one edge after a btn_pulse or limit hit; no backpressure.
module updown_dir_ctrl
  import updown_pkg::*;
#(
  parameter int               DEBOUNCE_CYCLES = 16,
  parameter logic [CNT_W-1:0] LOW_LIMIT       = LOW_LIMIT_DEF,
  parameter logic [CNT_W-1:0] HIGH_LIMIT      = HIGH_LIMIT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_raw,
  input  logic             enable,
  input  logic             auto_mode,
  input  logic [CNT_W-1:0] count_in,
  output logic             up_down,
  output logic             btn_pulse,
  output logic             dir_change
);

  // Turn one step early: the counter takes its next step on the same edge.
  localparam logic [CNT_W-1:0] HI_TURN = HIGH_LIMIT - CNT_W'(1);
  localparam logic [CNT_W-1:0] LO_TURN = LOW_LIMIT + CNT_W'(1);

  dir_state_e state_q, state_d;
  logic       up_down_q, dir_change_q;
  logic       armed_q;
  logic       pulse;
  logic       auto_flip;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk      (clk),
    .reset    (reset),
    .btn_raw  (btn_raw),
    .btn_pulse(pulse)
  );

  // Manual and auto requests are OR-ed so a coincidence yields one toggle;
  // armed_q blocks any flip on the first edge after reset release.
  always_comb begin
    auto_flip = auto_mode &&
                (((state_q == S_UP)   && (count_in >= HI_TURN)) ||
                 ((state_q == S_DOWN) && (count_in <= LO_TURN)));
    state_d   = state_q;
    if (armed_q && enable && (pulse || auto_flip)) begin
      state_d = dir_flip(state_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_DOWN;
      up_down_q    <= 1'b0;
      dir_change_q <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      up_down_q    <= (state_d == S_UP);
      dir_change_q <= (state_d != state_q);
      armed_q      <= 1'b1;
    end
  end

  assign up_down    = up_down_q;
  assign btn_pulse  = pulse;
  assign dir_change = dir_change_q;

endmodule

// File: tb/tb_updown_dir_ctrl.sv
// Scoreboard bench for updown_dir_ctrl: a history-based reference model queues
// expected pulse/turn events and a negedge monitor pops and compares them.
module tb_updown_dir_ctrl;

  localparam int DC = 4;
  localparam int LO = 0;
  localparam int HI = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_raw = 1'b0;
  logic       enable = 1'b0;
  logic       auto_mode = 1'b0;
  logic [3:0] count_in = 4'd0;
  logic       up_down, btn_pulse, dir_change;

  always #5 clk = ~clk;

  updown_dir_ctrl #(
    .DEBOUNCE_CYCLES(DC),
    .LOW_LIMIT      (4'(LO)),
    .HIGH_LIMIT     (4'(HI))
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (btn_raw),
    .enable    (enable),
    .auto_mode (auto_mode),
    .count_in  (count_in),
    .up_down   (up_down),
    .btn_pulse (btn_pulse),
    .dir_change(dir_change)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: edges since reset release, raw-input history.
  int ecount = 0;
  bit hist [0:8191];
  bit m_stable, m_state, m_pulse;
  int m_last_flip;
  int pulse_q[$];
  int dir_cyc_q[$];
  bit dir_val_q[$];

  // Downstream counter model, driven by the DUT direction.
  logic [3:0] cnt = 4'd0;
  logic [3:0] prev;
  bit         cnt_run = 1'b0;
  bit         ud_s;
  int         wraps, cmin, cmax;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, ecount);
    end
  endtask

  function automatic bit samp(input int k);
    return (k >= 1) ? hist[k] : 1'b0;
  endfunction

  // Synced level seen at edge e is the raw level from two edges earlier; a new
  // level is accepted once DEBOUNCE_CYCLES consecutive samples since the last
  // acceptance all differ from the current one.
  task automatic model_edge();
    bit acc, new_pulse, auto_c, turn;
    int e;
    ecount++;
    e = ecount;
    hist[e] = btn_raw;
    acc = (e - DC >= m_last_flip);
    for (int j = 0; j < DC; j++)
      if (samp(e - 2 - j) == m_stable) acc = 1'b0;
    new_pulse = acc && !m_stable;
    if (acc) begin
      m_stable    = !m_stable;
      m_last_flip = e;
    end
    auto_c = auto_mode && (m_state ? (int'(count_in) >= HI - 1) : (int'(count_in) <= LO + 1));
    turn   = (e > 1) && enable && (m_pulse || auto_c);
    if (turn) begin
      m_state = !m_state;
      dir_cyc_q.push_back(e);
      dir_val_q.push_back(m_state);
    end
    if (new_pulse) pulse_q.push_back(e);
    m_pulse = new_pulse;
  endtask

  task automatic step();
    @(negedge clk);
    ud_s = up_down;
    @(posedge clk);
    if (!reset) model_edge();
    #1;
    if (cnt_run && !reset) begin
      prev = cnt;
      cnt  = ud_s ? cnt + 4'd1 : cnt - 4'd1;
      if ((prev == 4'd15 && cnt == 4'd0) || (prev == 4'd0 && cnt == 4'd15)) wraps++;
      if (int'(cnt) < cmin) cmin = int'(cnt);
      if (int'(cnt) > cmax) cmax = int'(cnt);
    end
    count_in = cnt;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    #1;
    check("reset_outputs", int'({up_down, btn_pulse, dir_change}), 0);
    pulse_q.delete();
    dir_cyc_q.delete();
    dir_val_q.delete();
    ecount      = 0;
    m_state     = 1'b0;
    m_stable    = 1'b0;
    m_pulse     = 1'b0;
    m_last_flip = 0;
    repeat (n) step();
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (pulse_q.size() > 0 && pulse_q[0] < ecount) begin
        check("missing_pulse", -1, pulse_q[0]);
        void'(pulse_q.pop_front());
      end
      if (dir_cyc_q.size() > 0 && dir_cyc_q[0] < ecount) begin
        check("missing_dir_change", -1, dir_cyc_q[0]);
        void'(dir_cyc_q.pop_front());
        void'(dir_val_q.pop_front());
      end
      if (btn_pulse) begin
        if (pulse_q.size() == 0) check("spurious_pulse", ecount, -1);
        else check("pulse_cycle", ecount, pulse_q.pop_front());
      end
      if (dir_change) begin
        if (dir_cyc_q.size() == 0) check("spurious_dir_change", ecount, -1);
        else begin
          check("dir_change_cycle", ecount, dir_cyc_q.pop_front());
          check("up_down_after_turn", int'(up_down), int'(dir_val_q.pop_front()));
        end
      end
    end
  end

  initial begin
    bit ud0;
    int total;
    #2;
    enable = 1'b1;
    do_reset(2);

    // Idle after reset
    repeat (5) step();
    check("idle_up_down", int'(up_down), 0);

    // Clean press and release
    btn_raw = 1'b1;
    repeat (12) step();
    btn_raw = 1'b0;
    repeat (12) step();
    check("clean_press_up_down", int'(up_down), 1);

    // Bounce faster than the debounce window
    ud0 = up_down;
    repeat (10) begin
      btn_raw = ~btn_raw;
      repeat (2) step();
    end
    btn_raw = 1'b0;
    repeat (8) step();
    check("bounce_up_down", int'(up_down), int'(ud0));

    // Random button runs with random enable, manual mode only
    total = 0;
    while (total < 300) begin
      int len;
      len     = $urandom_range(1, 8);
      btn_raw = ~btn_raw;
      enable  = ($urandom_range(0, 3) != 0);
      repeat (len) step();
      total += len;
    end
    btn_raw = 1'b0;
    enable  = 1'b1;
    repeat (12) step();
    check("random_up_down", int'(up_down), int'(m_state));

    // Auto ping-pong with the counter loop closed
    cnt = 4'd0;
    count_in = 4'd0;
    auto_mode = 1'b1;
    step();
    wraps = 0; cmin = 15; cmax = 0;
    cnt_run = 1'b1;
    repeat (70) step();
    cnt_run = 1'b0;
    auto_mode = 1'b0;
    check("auto_wraps", wraps, 0);
    check("auto_peak", cmax, HI);
    check("auto_trough", cmin, LO);
    repeat (3) step();

    // Press while disabled: pulse appears, direction frozen
    enable = 1'b0;
    ud0 = up_down;
    btn_raw = 1'b1;
    repeat (10) step();
    btn_raw = 1'b0;
    repeat (10) step();
    check("disabled_up_down", int'(up_down), int'(ud0));

    // Reach S_UP away from the limits, then make press and auto turn coincide
    enable = 1'b1;
    cnt = 4'd7;
    count_in = 4'd7;
    if (!m_state) begin
      btn_raw = 1'b1;
      repeat (10) step();
      btn_raw = 1'b0;
      repeat (10) step();
    end
    check("pre_coincide_up", int'(up_down), 1);
    btn_raw = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (m_pulse) begin
        auto_mode = 1'b1;
        cnt = 4'd14;
        count_in = 4'd14;
        step();
        auto_mode = 1'b0;
        break;
      end
    end
    repeat (4) step();
    check("coincide_single_toggle", int'(up_down), 0);
    btn_raw = 1'b0;
    cnt = 4'd7;
    count_in = 4'd7;
    repeat (10) step();

    // Reset in the middle of a held press
    btn_raw = 1'b1;
    repeat (2) step();
    do_reset(2);
    repeat (6) step();
    check("post_reset_not_yet", int'(up_down), 0);
    repeat (6) step();
    check("post_reset_accepted", int'(up_down), 1);
    btn_raw = 1'b0;
    repeat (10) step();

    check("pending_pulse_events", pulse_q.size(), 0);
    check("pending_dir_events", dir_cyc_q.size(), 0);
    check("final_up_down", int'(up_down), int'(m_state));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
